id_ex_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS datapath.
- Sits directly downstream of the decode-stage immediate extenders: captures the zero-extended immediate (plus sign-extended and LUI forms), register-file operands, register addresses and control bits.
- Presents them to the EX stage one cycle later.
- Implements stall (hold), flush (bubble insertion) and a valid bit, so hazard logic can freeze or squash the stage.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/imm_select.sv | 24 ++
 rtl/id_ex_reg.sv | 124 ++++++++++++
 tb/tb_id_ex_reg.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: immediate-select codes, ALU op encodings
// and the packed control bundle carried down the pipeline.
package mips_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [1:0] IMM_SEXT = 2'b00;
    localparam logic [1:0] IMM_ZEXT = 2'b01;
    localparam logic [1:0] IMM_LUI  = 2'b10;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'h0;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'h1;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'h2;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'h3;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'h4;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'h6;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'h7;
    localparam logic [ALU_OP_W-1:0] ALU_LUI = 4'h8;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/imm_select.sv
// Combinational immediate selector (sext / zext / lui); shared with the
// forwarding and branch logic, so it stays free of any state.
module imm_select
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] imm_zext,
    input  logic [DATA_W-1:0] imm_sext,
    input  logic [1:0]        imm_sel,
    output logic [DATA_W-1:0] imm
);

    always_comb begin
        imm = imm_sext;
        case (imm_sel)
            IMM_ZEXT: imm = imm_zext;
            IMM_LUI:  imm = {imm_zext[15:0], {(DATA_W-16){1'b0}}};
            // reserved encoding 2'b11 falls back to the sign-extended form
            default:  imm = imm_sext;
        endcase
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall (hold), flush (bubble) and valid bit.
// Optional stall/bubble performance counters under ID_EX_PERF_CNT_EN.
module id_ex_reg
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic               stall,
    input  logic               flush,
    input  logic [DATA_W-1:0]  id_pc4,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm_zext,
    input  logic [DATA_W-1:0]  id_imm_sext,
    input  logic [1:0]         id_imm_sel,
    input  logic [REG_AW-1:0]  id_rs_addr,
    input  logic [REG_AW-1:0]  id_rt_addr,
    input  logic [REG_AW-1:0]  id_rd_addr,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               id_alu_src,
    input  logic               id_reg_dst,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_mem_to_reg,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_bubble_cnt,
`endif
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_pc4,
    output logic [DATA_W-1:0]  ex_rs_data,
    output logic [DATA_W-1:0]  ex_rt_data,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [REG_AW-1:0]  ex_rs_addr,
    output logic [REG_AW-1:0]  ex_rt_addr,
    output logic [REG_AW-1:0]  ex_wr_addr,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg
);

    ctrl_t             ctrl_d, ctrl_q;
    logic [DATA_W-1:0] imm_d;
    logic [REG_AW-1:0] wr_addr_d;

    imm_select #(.DATA_W(DATA_W)) u_imm_select (
        .imm_zext (id_imm_zext),
        .imm_sext (id_imm_sext),
        .imm_sel  (id_imm_sel),
        .imm      (imm_d)
    );

    assign wr_addr_d = id_reg_dst ? id_rd_addr : id_rt_addr;

    // An invalid decode slot must never carry live control into EX.
    always_comb begin
        ctrl_d = '0;
        if (id_valid) begin
            ctrl_d.alu_op     = ALU_OP_W'(id_alu_op);
            ctrl_d.alu_src    = id_alu_src;
            ctrl_d.reg_write  = id_reg_write;
            ctrl_d.mem_read   = id_mem_read;
            ctrl_d.mem_write  = id_mem_write;
            ctrl_d.mem_to_reg = id_mem_to_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            ex_valid   <= 1'b0;
            ctrl_q     <= '0;
            ex_pc4     <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs_addr <= '0;
            ex_rt_addr <= '0;
            ex_wr_addr <= '0;
        end else if (!stall) begin
            ex_valid   <= id_valid;
            ctrl_q     <= ctrl_d;
            ex_pc4     <= id_pc4;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= imm_d;
            ex_rs_addr <= id_rs_addr;
            ex_rt_addr <= id_rt_addr;
            ex_wr_addr <= wr_addr_d;
        end
    end

    assign ex_alu_op     = ALUOP_W'(ctrl_q.alu_op);
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;

`ifdef ID_EX_PERF_CNT_EN
    // Saturating counters; a flush edge counts as a bubble even if stall is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else if (flush) begin
            if (perf_bubble_cnt != 32'hFFFF_FFFF)
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end else if (stall) begin
            if (perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, immediate select, wr-addr mux, stall,
// flush, invalid slot and (when ID_EX_PERF_CNT_EN is defined) perf counters.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, stall, flush;
    logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm_zext, id_imm_sext;
    logic [1:0]  id_imm_sel;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        ex_valid;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs_addr, ex_rt_addr, ex_wr_addr;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_bubble_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .stall         (stall),
        .flush         (flush),
        .id_pc4        (id_pc4),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .id_imm_zext   (id_imm_zext),
        .id_imm_sext   (id_imm_sext),
        .id_imm_sel    (id_imm_sel),
        .id_rs_addr    (id_rs_addr),
        .id_rt_addr    (id_rt_addr),
        .id_rd_addr    (id_rd_addr),
        .id_alu_op     (id_alu_op),
        .id_alu_src    (id_alu_src),
        .id_reg_dst    (id_reg_dst),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .id_mem_to_reg (id_mem_to_reg),
`ifdef ID_EX_PERF_CNT_EN
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt),
`endif
        .ex_valid      (ex_valid),
        .ex_pc4        (ex_pc4),
        .ex_rs_data    (ex_rs_data),
        .ex_rt_data    (ex_rt_data),
        .ex_imm        (ex_imm),
        .ex_rs_addr    (ex_rs_addr),
        .ex_rt_addr    (ex_rt_addr),
        .ex_wr_addr    (ex_wr_addr),
        .ex_alu_op     (ex_alu_op),
        .ex_alu_src    (ex_alu_src),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with every input non-zero
        rst_n = 1'b0; id_valid = 1'b1; stall = 1'b1; flush = 1'b1;
        id_pc4 = 32'h0000_0104; id_rs_data = 32'h1111_1111; id_rt_data = 32'h2222_2222;
        id_imm_zext = 32'h0000_BEEF; id_imm_sext = 32'hFFFF_BEEF; id_imm_sel = 2'b01;
        id_rs_addr = 5'd1; id_rt_addr = 5'd3; id_rd_addr = 5'd7;
        id_alu_op = 4'h2; id_alu_src = 1'b1; id_reg_dst = 1'b1;
        id_reg_write = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b1; id_mem_to_reg = 1'b1;
        tick(); tick();
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_pc4", ex_pc4, 32'd0);
        chk("rst_imm", ex_imm, 32'd0);
        chk("rst_wr_addr", {27'd0, ex_wr_addr}, 32'd0);
        chk("rst_ctrl", {23'd0, ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read,
                         ex_mem_write, ex_mem_to_reg}, 32'd0);

        // load, zext immediate, rd destination
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
        id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
        tick();
        chk("ld_valid", {31'd0, ex_valid}, 32'd1);
        chk("ld_imm_zext", ex_imm, 32'h0000_BEEF);
        chk("ld_wr_rd", {27'd0, ex_wr_addr}, 32'd7);
        chk("ld_pc4", ex_pc4, 32'h0000_0104);
        chk("ld_rs_data", ex_rs_data, 32'h1111_1111);
        chk("ld_rt_data", ex_rt_data, 32'h2222_2222);
        chk("ld_addrs", {22'd0, ex_rs_addr, ex_rt_addr}, {22'd0, 5'd1, 5'd3});
        chk("ld_alu_op", {28'd0, ex_alu_op}, 32'h2);
        chk("ld_ctrl", {27'd0, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
                        ex_mem_to_reg}, 32'b11000);

        id_imm_sel = 2'b10;
        tick();
        chk("imm_lui", ex_imm, 32'hBEEF_0000);
        id_imm_sel = 2'b11;
        tick();
        chk("imm_rsvd", ex_imm, 32'hFFFF_BEEF);
        id_imm_sel = 2'b00; id_reg_dst = 1'b0; id_mem_read = 1'b1; id_mem_to_reg = 1'b1;
        tick();
        chk("imm_sext", ex_imm, 32'hFFFF_BEEF);
        chk("wr_rt", {27'd0, ex_wr_addr}, 32'd3);
        chk("ld_memrd", {30'd0, ex_mem_read, ex_mem_to_reg}, 32'b11);

        // stall for 3 cycles while ID changes
        id_pc4 = 32'h0000_0200; id_rs_data = 32'hAAAA_0001;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_pc4 = 32'h0000_0A00 + 32'(i); id_rs_data = 32'h5555_0000 + 32'(i);
            id_imm_sel = 2'b01; id_reg_dst = 1'b1;
            tick();
            chk("stall_pc4", ex_pc4, 32'h0000_0200);
            chk("stall_rs", ex_rs_data, 32'hAAAA_0001);
            chk("stall_imm", ex_imm, 32'hFFFF_BEEF);
        end
        stall = 1'b0; id_pc4 = 32'h0000_0300;
        tick();
        chk("unstall_pc4", ex_pc4, 32'h0000_0300);
        chk("unstall_imm", ex_imm, 32'h0000_BEEF);
        chk("unstall_wr", {27'd0, ex_wr_addr}, 32'd7);

        // flush overrides stall
        stall = 1'b1; flush = 1'b1; id_reg_write = 1'b1; id_mem_write = 1'b1;
        tick();
        chk("fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_ctrl", {23'd0, ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read,
                        ex_mem_write, ex_mem_to_reg}, 32'd0);
        chk("fl_pc4", ex_pc4, 32'd0);

        // invalid ID slot never carries control
        stall = 1'b0; flush = 1'b0; id_valid = 1'b0; id_pc4 = 32'h0000_0400;
        tick();
        chk("inv_valid", {31'd0, ex_valid}, 32'd0);
        chk("inv_ctrl", {23'd0, ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read,
                         ex_mem_write, ex_mem_to_reg}, 32'd0);
        chk("inv_pc4", ex_pc4, 32'h0000_0400);

        // reset during a stall, then a normal load
        id_valid = 1'b1; id_pc4 = 32'h0000_0500;
        tick();
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        stall = 1'b1; rst_n = 1'b0;
        tick();
        chk("rst_stall_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_stall_pc4", ex_pc4, 32'd0);
        rst_n = 1'b1; stall = 1'b0; id_pc4 = 32'h0000_0600;
        tick();
        chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);
        chk("post_rst_pc4", ex_pc4, 32'h0000_0600);

`ifdef ID_EX_PERF_CNT_EN
        // counters were cleared by the reset above; the following load edge counts nothing
        stall = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        stall = 1'b0; flush = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        flush = 1'b0;
        tick();
        chk("perf_stall", perf_stall_cnt, 32'd4);
        chk("perf_bubble", perf_bubble_cnt, 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
